// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux, with a per-grant
// burst cap and a valid/ready handshake toward the downstream consumer.
module mux_2x1_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             s,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  input  logic             y_ready
);

  localparam int unsigned     CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               gnt_a_q, gnt_a_d;
  logic               gnt_b_q, gnt_b_d;
  logic               s_q, s_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               beat;
  logic               own_req;
  logic               oth_req;
  logic               enter;

  assign y       = s_q ? data_b : data_a;
  assign y_valid = (gnt_a_q & req_a) | (gnt_b_q & req_b);
  assign beat    = y_valid & y_ready;
  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign s       = s_q;

  // Next state: release on withdrawal or on the burst-limit beat, then prefer the other side.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    s_d     = s_q;
    enter   = 1'b0;
    own_req = 1'b0;
    oth_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_q)) begin
          state_d = GRANT_A;
          enter   = 1'b1;
        end else if (req_b) begin
          state_d = GRANT_B;
          enter   = 1'b1;
        end
      end
      GRANT_A, GRANT_B: begin
        own_req = (state_q == GRANT_A) ? req_a : req_b;
        oth_req = (state_q == GRANT_A) ? req_b : req_a;
        if (!own_req || (beat && (cnt_q == CNT_LAST))) begin
          enter = 1'b1;
          if (oth_req) begin
            state_d = (state_q == GRANT_A) ? GRANT_B : GRANT_A;
          end else if (!own_req) begin
            state_d = IDLE;
            enter   = 1'b0;
          end
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter) begin
      cnt_d = '0;
    end
    if (state_d == GRANT_A) begin
      s_d    = 1'b0;
      last_d = 1'b0;
    end else if (state_d == GRANT_B) begin
      s_d    = 1'b1;
      last_d = 1'b1;
    end
    gnt_a_d = (state_d == GRANT_A);
    gnt_b_d = (state_d == GRANT_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Bench for mux_2x1_rr_arbiter: directed scenarios with literal expectations plus
// a grant-ownership model compared against the DUT every cycle.
module tb_mux_2x1_rr_arbiter;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_BURST = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] data_a, data_b;
  logic             gnt_a, gnt_b, s;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;

  int n_checks = 0;
  int n_pass   = 0;

  mux_2x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .data_a  (data_a),
    .req_b   (req_b),
    .data_b  (data_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .s       (s),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: who owns the mux (0 none, 1 A, 2 B), beats taken in this grant, who went last.
  int owner = 0;
  int beats = 0;
  int nxt;
  bit last_b = 1'b1;
  bit m_s = 1'b0;
  bit model_ok = 1'b0;
  bit m_beat, m_enter, rq_own, rq_oth;

  always @(posedge clk) begin
    if (rst) begin
      owner = 0; beats = 0; last_b = 1'b1; m_s = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      m_beat  = (((owner == 1) && req_a) || ((owner == 2) && req_b)) && y_ready;
      m_enter = 1'b0;
      nxt     = owner;
      if (owner == 0) begin
        if (req_a && (!req_b || last_b)) nxt = 1;
        else if (req_b) nxt = 2;
        m_enter = (nxt != 0);
      end else begin
        rq_own = (owner == 1) ? req_a : req_b;
        rq_oth = (owner == 1) ? req_b : req_a;
        if (m_beat) beats++;
        if (!rq_own || beats == int'(MAX_BURST)) begin
          if (rq_oth) nxt = 3 - owner;
          else if (rq_own) nxt = owner;
          else nxt = 0;
          m_enter = (nxt != 0);
        end
      end
      if (m_enter) begin
        beats  = 0;
        last_b = (nxt == 2);
        m_s    = (nxt == 2);
      end
      owner = nxt;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_gnt_a", 32'(gnt_a), 32'(owner == 1));
      check("m_gnt_b", 32'(gnt_b), 32'(owner == 2));
      check("m_s", 32'(s), 32'(m_s));
      check("m_y_valid", 32'(y_valid), 32'(((owner == 1) && req_a) || ((owner == 2) && req_b)));
      check("m_y", 32'(y), 32'(m_s ? data_b : data_a));
      check("m_onehot", 32'(gnt_a & gnt_b), 32'(0));
    end
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    data_a = '0; data_b = '0; y_ready = 1'b0;

    // Reset held for two edges with no requests
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_gnt_a", 32'(gnt_a), 32'(0));
      check("rst_gnt_b", 32'(gnt_b), 32'(0));
      check("rst_s", 32'(s), 32'(0));
      check("rst_y_valid", 32'(y_valid), 32'(0));
    end
    rst = 1'b0;
    tick();
    check("idle_gnt_a", 32'(gnt_a), 32'(0));
    check("idle_gnt_b", 32'(gnt_b), 32'(0));

    // Single requester: A keeps the mux, re-granted every 4 beats with no gap
    req_a = 1'b1; data_a = 8'h5A; y_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("single_gnt_a", 32'(gnt_a), 32'(1));
      check("single_y", 32'(y), 32'h5A);
      check("single_y_valid", 32'(y_valid), 32'(1));
      tick();
    end
    req_a = 1'b0;
    tick();
    check("single_release", 32'(gnt_a), 32'(0));

    // Contention from reset: A,A,A,A,B,B,B,B,...
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = 1'b1; req_b = 1'b1; data_a = 8'h11; data_b = 8'h22; y_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("cont_s", 32'(s), 32'((i / 4) % 2));
      check("cont_gnt_a", 32'(gnt_a), 32'(((i / 4) % 2) == 0));
      check("cont_y_valid", 32'(y_valid), 32'(1));
      check("cont_y", 32'(y), (((i / 4) % 2) == 1) ? 32'h22 : 32'h11);
    end

    // Backpressure: stalls mid-burst do not count
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick();
    rst = 1'b0; req_a = 1'b1; y_ready = 1'b1;
    tick(); tick(); tick();
    y_ready = 1'b0; req_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_gnt_a", 32'(gnt_a), 32'(1));
      check("stall_s", 32'(s), 32'(0));
      tick();
    end
    y_ready = 1'b1;
    check("stall_resume_a", 32'(gnt_a), 32'(1));
    tick();
    check("stall_beat4_a", 32'(gnt_a), 32'(1));
    tick();
    check("stall_switch_b", 32'(gnt_b), 32'(1));
    check("stall_switch_s", 32'(s), 32'(1));

    // B withdraws after 2 beats, then A withdraws after 2 beats
    tick(); tick();
    req_b = 1'b0;
    tick();
    check("wd_b_gnt_a", 32'(gnt_a), 32'(1));
    check("wd_b_s", 32'(s), 32'(0));
    req_b = 1'b1;
    tick(); tick();
    req_a = 1'b0;
    tick();
    check("wd_a_gnt_b", 32'(gnt_b), 32'(1));
    check("wd_a_s", 32'(s), 32'(1));
    check("wd_a_gnt_a", 32'(gnt_a), 32'(0));

    // Reset mid-grant with B at cnt 2; A wins afterwards
    tick(); tick();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    tick();
    check("mrst_gnt_b", 32'(gnt_b), 32'(0));
    check("mrst_gnt_a", 32'(gnt_a), 32'(0));
    check("mrst_s", 32'(s), 32'(0));
    check("mrst_y_valid", 32'(y_valid), 32'(0));
    rst = 1'b0;
    tick();
    check("mrst_first_a", 32'(gnt_a), 32'(1));
    check("mrst_first_s", 32'(s), 32'(0));

    // Deterministic sweep of request/ready patterns, checked by the model
    for (int i = 0; i < 300; i++) begin
      req_a   = (i % 7) != 3;
      req_b   = (i % 5) < 3;
      y_ready = (i % 3) != 1;
      data_a  = WIDTH'(i);
      data_b  = WIDTH'(8'hFF - i);
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    check("end_idle", 32'(gnt_a | gnt_b), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_2x1_rr_arbiter.md
# mux_2x1_rr_arbiter

Round-robin arbiter and sequencer for a shared 2:1 multiplexer. Two requesters, A and B, compete for one downstream output. The block grants one requester at a time and drives the mux select `s`. It forwards the granted requester's data through a valid/ready handshake and caps each grant at `MAX_BURST` accepted beats so that neither side can starve the other.

## Interface
Parameters:
- `WIDTH`, default 8: data width of each requester and of `y`.
- `MAX_BURST`, default 4: maximum beats accepted per grant. Legal range is 1..255.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_a`, input, 1: requester A has data to send.
- `data_a`, input, WIDTH: requester A data. Must be held stable while `req_a` is high and no beat is accepted.
- `req_b`, input, 1: requester B has data to send.
- `data_b`, input, WIDTH: requester B data. Same stability rule as `data_a`.
- `gnt_a`, output, 1: registered; A owns the mux.
- `gnt_b`, output, 1: registered; B owns the mux.
- `s`, output, 1: registered mux select; 0 selects A, 1 selects B.
- `y`, output, WIDTH: combinational; equals `s ? data_b : data_a`.
- `y_valid`, output, 1: combinational; equals `(gnt_a & req_a) | (gnt_b & req_b)`.
- `y_ready`, input, 1: downstream accepts `y` when `y_valid & y_ready`; this event is a "beat".

## Operation
- The FSM has three states: IDLE, GRANT_A and GRANT_B. Outputs by state:
  - IDLE: `gnt_a` = 0, `gnt_b` = 0.
  - GRANT_A: `gnt_a` = 1, `s` = 0.
  - GRANT_B: `gnt_b` = 1, `s` = 1.
  - In IDLE, `s` holds its last value.
- State registers: `last` records the requester most recently granted (0 = A, 1 = B). An 8-bit beat counter `cnt` tracks beats in the current grant.
- Reset values: state IDLE, `gnt_a` = 0, `gnt_b` = 0, `s` = 0, `cnt` = 0, `last` = 1. The `last` reset value gives A first priority. Consequently `y_valid` = 0 out of reset.
- From IDLE:
  - Only `req_a` high: go to GRANT_A.
  - Only `req_b` high: go to GRANT_B.
  - Both high: grant the requester that is not `last`.
  - Neither high: stay in IDLE.
  - `cnt` is cleared on entry to any grant state.
- While in GRANT_X (X is A or B):
  - `cnt` increments on each beat.
  - `cnt` holds when `y_ready` is 0 (stall). Stalls do not count toward the burst.
- A grant is released on the edge where either of these holds:
  - `req_X` is 0 (withdrawal; allowed even while stalled, and no beat occurs), or
  - a beat occurs with `cnt == MAX_BURST-1` (burst limit reached).
- On release:
  - If the other requester's req is high, go directly to the other grant state with no idle bubble. Update `last` and clear `cnt`.
  - Otherwise, if `req_X` is still high (burst limit case), re-grant X with `cnt` cleared.
  - Otherwise, go to IDLE.
- `last` is updated to X on every entry to GRANT_X.

## Timing
- Grant latency: a req sampled high in IDLE gives gnt/`s` high on the next edge. The first beat is possible in that following cycle. Minimum request-to-first-beat is 1 cycle.
- Switch latency: the release edge and the new grant coincide. The last A beat in cycle N is followed by the first B beat possible in cycle N+1.
- `s` and the gnt signals always change on the same edge. `gnt_a & gnt_b` is never 1.
- `y` and `y_valid` follow the inputs combinationally within the cycle. The downstream may register them.
- Simultaneous events:
  - Release plus other req high: switch.
  - Both reqs rising together in IDLE: round-robin decides.
  - Withdrawal coinciding with the burst-limit beat: the beat counts, then release.
- `rst` asserted mid-grant: on the next edge the block is in IDLE with all reset values, regardless of req or `y_ready`. Any in-flight beat in that cycle is still accepted downstream; the block does not retract it.
- `MAX_BURST` = 1: each beat releases the grant, so the requesters alternate beat-by-beat while both are requesting.

## Test plan
- Reset then idle: hold `rst` = 1 for 2 cycles with `req_a` = `req_b` = 0. Expect `gnt_a` = `gnt_b` = 0, `s` = 0, `y_valid` = 0 throughout, and IDLE after `rst` drops.
- Single requester: set `req_a` = 1, `data_a` = 8'h5A, `y_ready` = 1 for 10 cycles. Expect `gnt_a` = 1 from cycle 1, `y` = 8'h5A, and `y_valid` = 1. Since B is idle, A is re-granted after every 4 beats with no gap.
- Contention: raise `req_a` and `req_b` together from IDLE with `y_ready` = 1. Expect A granted first for exactly 4 beats, then B granted on the next edge (`s` = 1) for 4 beats, then A again. There is no cycle with `y_valid` = 0.
- Backpressure: A granted, `y_ready` = 0 for 3 cycles mid-burst. Expect `cnt` frozen and the grant kept. The burst completes 4 accepted beats only after `y_ready` returns to 1.
- Withdrawal: A granted, `req_a` drops after 2 beats while `req_b` = 1. Expect `gnt_b` = 1 and `s` = 1 on the next edge; A is credited only 2 beats.
- Reset mid-grant: B granted with `cnt` = 2, assert `rst` for 1 cycle. Expect `gnt_b` = 0 and `s` = 0 next edge. When both reqs are then high, A is granted first.
